// File: rtl/multi_phase_signal_controller.sv
// N-phase intersection controller: round-robin green service with min/max green,
// demand gap-out, yellow and all-red clearance, and a flashing fail-safe mode.
module multi_phase_signal_controller #(
    parameter int NUM_PHASES = 4,
    parameter int GREEN_MIN  = 10,
    parameter int GREEN_MAX  = 40,
    parameter int YELLOW_T   = 4,
    parameter int ALLRED_T   = 2,
    parameter int FLASH_HALF = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PHASES-1:0]           demand,
    input  logic                            flash,
    output logic [2*NUM_PHASES-1:0]         lights,
    output logic [$clog2(NUM_PHASES)-1:0]   active_phase,
    output logic                            phase_start,
    output logic                            in_flash
);

    localparam int AW   = $clog2(NUM_PHASES);
    localparam int T1   = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
    localparam int T2   = (T1 > ALLRED_T) ? T1 : ALLRED_T;
    localparam int TMAX = (T2 > 2 * FLASH_HALF) ? T2 : 2 * FLASH_HALF;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] G_MIN_END  = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] G_MAX_END  = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] Y_END      = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] R_END      = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] F_HALF_END = TW'(FLASH_HALF - 1);
    localparam logic [TW-1:0] F_END      = TW'(2 * FLASH_HALF - 1);

    localparam logic [2*NUM_PHASES-1:0] ALL_YELLOW = {NUM_PHASES{2'b01}};
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    typedef enum logic [1:0] {
        GREEN,
        YELLOW,
        ALLRED,
        FLASH
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [AW-1:0]   next_phase;
    logic [AW-1:0]   scan_phase;
    logic [AW-1:0]   cand;
    logic            other_demand;
    logic            leave_green;

    function automatic logic [2*NUM_PHASES-1:0] one_lamp(input logic [AW-1:0] p,
                                                         input logic [1:0]    code);
        one_lamp = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (AW'(i) == p) one_lamp[2*i +: 2] = code;
        end
    endfunction

    // Scan downward so the nearest demanding phase after active_phase wins;
    // with no other demand the default is simply the following phase.
    always_comb begin
        scan_phase   = (active_phase == AW'(NUM_PHASES - 1)) ? '0 : active_phase + AW'(1);
        other_demand = 1'b0;
        cand         = '0;
        for (int k = NUM_PHASES - 1; k >= 1; k--) begin
            cand = AW'((int'(active_phase) + k) % NUM_PHASES);
            if (demand[cand]) begin
                scan_phase   = cand;
                other_demand = 1'b1;
            end
        end
    end

    assign leave_green = (timer >= G_MIN_END) &&
                         (flash || (other_demand && (!demand[active_phase] || timer == G_MAX_END)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= GREEN;
            timer        <= '0;
            active_phase <= '0;
            next_phase   <= '0;
            lights       <= one_lamp('0, LAMP_GREEN);
            phase_start  <= 1'b0;
            in_flash     <= 1'b0;
        end else begin
            phase_start <= 1'b0;
            case (state)
                GREEN: begin
                    if (leave_green) begin
                        state      <= YELLOW;
                        timer      <= '0;
                        next_phase <= scan_phase;
                        lights     <= one_lamp(active_phase, LAMP_YELLOW);
                    end else if (timer != G_MAX_END) begin
                        timer <= timer + 1'b1;
                    end
                end
                YELLOW: begin
                    if (timer == Y_END) begin
                        state  <= ALLRED;
                        timer  <= '0;
                        lights <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ALLRED: begin
                    if (timer == R_END) begin
                        timer <= '0;
                        if (flash) begin
                            state    <= FLASH;
                            in_flash <= 1'b1;
                            lights   <= ALL_YELLOW;
                        end else begin
                            state        <= GREEN;
                            active_phase <= next_phase;
                            lights       <= one_lamp(next_phase, LAMP_GREEN);
                            phase_start  <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                FLASH: begin
                    // Recovery always restarts service from phase 0.
                    if (!flash) begin
                        state      <= ALLRED;
                        timer      <= '0;
                        lights     <= '0;
                        in_flash   <= 1'b0;
                        next_phase <= '0;
                    end else if (timer == F_END) begin
                        timer  <= '0;
                        lights <= ALL_YELLOW;
                    end else begin
                        timer <= timer + 1'b1;
                        if (timer == F_HALF_END) lights <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_phase_signal_controller.sv
// Scoreboard bench for multi_phase_signal_controller: per-cycle expected outputs,
// derived from the phase timing rules, are queued with the inputs to drive.
module tb_multi_phase_signal_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] demand = 4'b0000;
    logic       flash = 1'b0;
    logic [7:0] lights;
    logic [1:0] active_phase;
    logic       phase_start;
    logic       in_flash;
    logic [11:0] obs;

    typedef struct {
        logic [11:0] exp;
        logic [3:0]  dem;
        logic        fl;
    } step_t;

    step_t      sb[$];
    logic [3:0] cur_dem = 4'b0000;
    logic       cur_fl = 1'b0;
    int         tests_run = 0;
    int         tests_failed = 0;

    multi_phase_signal_controller #(
        .NUM_PHASES(4), .GREEN_MIN(10), .GREEN_MAX(40),
        .YELLOW_T(4), .ALLRED_T(2), .FLASH_HALF(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .demand(demand),
        .flash(flash),
        .lights(lights),
        .active_phase(active_phase),
        .phase_start(phase_start),
        .in_flash(in_flash)
    );

    always #5 clk = ~clk;

    assign obs = {lights, active_phase, phase_start, in_flash};

    function automatic logic [7:0] lamp(input int p, input logic [1:0] code);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (i == p) v[2*i +: 2] = code;
        end
        return v;
    endfunction

    // Queue n cycles of expected output; phase_start only on the first of them.
    function automatic void push(input logic [7:0] l, input int p, input logic ps,
                                 input logic fl, input int n);
        for (int i = 0; i < n; i++) begin
            step_t s;
            s.exp = {l, 2'(p), (i == 0) ? ps : 1'b0, fl};
            s.dem = cur_dem;
            s.fl  = cur_fl;
            sb.push_back(s);
        end
    endfunction

    function automatic void push_green(input int p, input int n, input logic ps);
        push(lamp(p, 2'b10), p, ps, 1'b0, n);
    endfunction

    function automatic void push_yellow(input int p, input int n);
        push(lamp(p, 2'b01), p, 1'b0, 1'b0, n);
    endfunction

    function automatic void push_allred(input int p, input int n);
        push(8'h00, p, 1'b0, 1'b0, n);
    endfunction

    function automatic void push_flash(input int p, input int n, input logic on);
        push(on ? 8'h55 : 8'h00, p, 1'b0, 1'b1, n);
    endfunction

    task automatic do_reset(input logic [3:0] d);
        reset   = 1'b1;
        demand  = d;
        flash   = 1'b0;
        cur_dem = d;
        cur_fl  = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step_t s;
        int c;
        do_reset(4'b0000);
        push_green(0, 100, 1'b0);
        c = 0;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            if (c > 0) begin @(posedge clk); #1; end
            tests_run++;
            if (obs !== s.exp) begin
                tests_failed++;
                $display("[TB] FAIL reset_hold cycle %0d: got %h, expected %h", c, obs, s.exp);
            end
            demand = s.dem;
            flash  = s.fl;
            c++;
        end
    endtask

    task automatic test_gap_out();
        step_t s;
        int c;
        do_reset(4'b0100);
        push_green(0, 10, 1'b0);
        push_yellow(0, 4);
        push_allred(0, 2);
        push_green(2, 5, 1'b1);
        c = 0;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            if (c > 0) begin @(posedge clk); #1; end
            tests_run++;
            if (obs !== s.exp) begin
                tests_failed++;
                $display("[TB] FAIL gap_out cycle %0d: got %h, expected %h", c, obs, s.exp);
            end
            demand = s.dem;
            flash  = s.fl;
            c++;
        end
    endtask

    task automatic test_max_out();
        step_t s;
        int c;
        do_reset(4'b0011);
        push_green(0, 40, 1'b0);
        push_yellow(0, 4);
        push_allred(0, 2);
        push_green(1, 40, 1'b1);
        push_yellow(1, 4);
        push_allred(1, 2);
        push_green(0, 3, 1'b1);
        c = 0;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            if (c > 0) begin @(posedge clk); #1; end
            tests_run++;
            if (obs !== s.exp) begin
                tests_failed++;
                $display("[TB] FAIL max_out cycle %0d: got %h, expected %h", c, obs, s.exp);
            end
            demand = s.dem;
            flash  = s.fl;
            c++;
        end
    endtask

    task automatic test_skip_wrap();
        step_t s;
        int c;
        do_reset(4'b0010);
        push_green(0, 10, 1'b0);
        push_yellow(0, 4);
        push_allred(0, 2);
        cur_dem = 4'b1010;
        push_green(1, 40, 1'b1);
        push_yellow(1, 4);
        push_allred(1, 2);
        cur_dem = 4'b0110;
        push_green(3, 10, 1'b1);
        push_yellow(3, 4);
        push_allred(3, 2);
        push_green(1, 3, 1'b1);
        c = 0;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            if (c > 0) begin @(posedge clk); #1; end
            tests_run++;
            if (obs !== s.exp) begin
                tests_failed++;
                $display("[TB] FAIL skip_wrap cycle %0d: got %h, expected %h", c, obs, s.exp);
            end
            demand = s.dem;
            flash  = s.fl;
            c++;
        end
    endtask

    task automatic test_flash();
        step_t s;
        int c;
        do_reset(4'b0000);
        push_green(0, 3, 1'b0);
        cur_fl = 1'b1;
        push_green(0, 7, 1'b0);
        push_yellow(0, 4);
        push_allred(0, 2);
        cur_dem = 4'b0100;
        push_flash(0, 8, 1'b1);
        push_flash(0, 8, 1'b0);
        push_flash(0, 2, 1'b1);
        cur_fl = 1'b0;
        push_flash(0, 1, 1'b1);
        push_allred(0, 2);
        push_green(0, 10, 1'b1);
        push_yellow(0, 4);
        push_allred(0, 2);
        push_green(2, 2, 1'b1);
        c = 0;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            if (c > 0) begin @(posedge clk); #1; end
            tests_run++;
            if (obs !== s.exp) begin
                tests_failed++;
                $display("[TB] FAIL flash cycle %0d: got %h, expected %h", c, obs, s.exp);
            end
            demand = s.dem;
            flash  = s.fl;
            c++;
        end
    endtask

    task automatic test_async_reset();
        step_t s;
        int c;
        do_reset(4'b0100);
        push_green(0, 10, 1'b0);
        push_yellow(0, 4);
        push_allred(0, 2);
        cur_dem = 4'b0001;
        push_green(2, 10, 1'b1);
        push_yellow(2, 2);
        c = 0;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            if (c > 0) begin @(posedge clk); #1; end
            tests_run++;
            if (obs !== s.exp) begin
                tests_failed++;
                $display("[TB] FAIL pre_reset cycle %0d: got %h, expected %h", c, obs, s.exp);
            end
            demand = s.dem;
            flash  = s.fl;
            c++;
        end
        // Mid-yellow of phase 2, well before the next rising edge.
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (obs !== {8'b00000010, 2'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got %h, expected %h", obs, {8'b00000010, 2'd0, 1'b0, 1'b0});
        end
        do_reset(4'b0100);
        push_green(0, 10, 1'b0);
        push_yellow(0, 4);
        push_allred(0, 2);
        push_green(2, 2, 1'b1);
        c = 0;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            if (c > 0) begin @(posedge clk); #1; end
            tests_run++;
            if (obs !== s.exp) begin
                tests_failed++;
                $display("[TB] FAIL post_reset cycle %0d: got %h, expected %h", c, obs, s.exp);
            end
            demand = s.dem;
            flash  = s.fl;
            c++;
        end
    endtask

    initial begin
        test_reset();
        test_gap_out();
        test_max_out();
        test_skip_wrap();
        test_flash();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
